conv_pool_sched: RTL and testbench

Layer scheduler for the fused convolution+pooling engine. Accepts a batch command and issues one start_conv per image. Turns the engine's ifm_read/wgt_read strobes into IFM/weight memory addresses. Turns pooled out_valid beats into output-buffer write addresses, and reports completion, progress and timeout/count errors. Sits between the layer control CSRs, the IFM/weight/OFM SRAMs and the engine, all on the compute clock.

---
 rtl/conv_pool_sched_if.sv | 35 +++
 rtl/conv_pool_sched.sv | 128 ++++++++++++
 tb/tb_conv_pool_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pool_sched_if.sv
// Bus between the layer scheduler (master) and the CSR block, engine and OFM SRAM (slave).
// Every control line is a single-cycle strobe sampled at the rising edge of clk1; there is no back-pressure.
interface conv_pool_sched_if #(
   parameter int ADDR_WIDTH    = 16,
   parameter int IMG_CNT_WIDTH = 8
);
   logic                     cmd_start;
   logic [IMG_CNT_WIDTH-1:0] cmd_num_img;
   logic                     busy;
   logic                     done;
   logic                     error;
   logic [IMG_CNT_WIDTH-1:0] img_idx;
   logic                     start_conv;
   logic                     ifm_read;
   logic [ADDR_WIDTH-1:0]    ifm_addr;
   logic                     wgt_read;
   logic [ADDR_WIDTH-1:0]    wgt_addr;
   logic                     out_valid;
   logic                     end_pool;
   logic                     ofm_we;
   logic [ADDR_WIDTH-1:0]    ofm_addr;
   logic [2:0]               fsm_state;

   modport master (
      input  cmd_start, cmd_num_img, ifm_read, wgt_read, out_valid, end_pool,
      output busy, done, error, img_idx, start_conv, ifm_addr, wgt_addr,
             ofm_we, ofm_addr, fsm_state
   );

   modport slave (
      output cmd_start, cmd_num_img, ifm_read, wgt_read, out_valid, end_pool,
      input  busy, done, error, img_idx, start_conv, ifm_addr, wgt_addr,
             ofm_we, ofm_addr, fsm_state
   );
endinterface

// File: rtl/conv_pool_sched.sv
// Batch scheduler for the fused conv+pool engine: issues start_conv per image and
// turns engine read/result strobes into IFM, weight and OFM SRAM addresses.
module conv_pool_sched #(
   parameter int IFM_SIZE       = 27,
   parameter int KERNEL_SIZE    = 5,
   parameter int STRIDE         = 1,
   parameter int PAD            = 2,
   parameter int KERNEL_POOL    = 3,
   parameter int STRIDE_POOL    = 2,
   parameter int CI             = 3,
   parameter int CO             = 8,
   parameter int ADDR_WIDTH     = 16,
   parameter int IMG_CNT_WIDTH  = 8,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic               clk1,
   input logic               rst,
   conv_pool_sched_if.master bus
);
   localparam int CONV_SIZE = (IFM_SIZE - KERNEL_SIZE + 2 * PAD) / STRIDE + 1;
   localparam int POOL_SIZE = (CONV_SIZE - KERNEL_POOL) / STRIDE_POOL + 1;
   localparam int IFM_WORDS = IFM_SIZE * IFM_SIZE * CI;
   localparam int WGT_WORDS = KERNEL_SIZE * KERNEL_SIZE * CI * CO;
   localparam int OUT_WORDS = POOL_SIZE * POOL_SIZE * CO;
   localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [ADDR_WIDTH-1:0] IFM_LAST  = ADDR_WIDTH'(IFM_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] IFM_STEP  = ADDR_WIDTH'(IFM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] WGT_LAST  = ADDR_WIDTH'(WGT_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] OUT_FULL  = ADDR_WIDTH'(OUT_WORDS);
   localparam logic [TW-1:0]         IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, START, RUN, NEXT, DONE} state_t;

   state_t                   state, state_next;
   logic [IMG_CNT_WIDTH-1:0] num_img, img_idx;
   logic [ADDR_WIDTH-1:0]    ifm_base, ofm_base, ifm_cnt, wgt_cnt, out_cnt, end_cnt;
   logic [TW-1:0]            idle_cnt;
   logic                     error, accept, active, out_ok, timeout, last_img, clr_cnt;

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      active     = bus.ifm_read | bus.wgt_read | bus.out_valid;
      out_ok     = bus.out_valid && (out_cnt != OUT_FULL);
      end_cnt    = out_cnt + ADDR_WIDTH'(out_ok);
      timeout    = !active && (idle_cnt == IDLE_LAST);
      last_img   = (img_idx == num_img - IMG_CNT_WIDTH'(1));
      case (state)
         IDLE: begin
            if (bus.cmd_start) begin
               accept     = 1'b1;
               state_next = (bus.cmd_num_img == '0) ? DONE : START;
            end
         end
         START: state_next = RUN;
         RUN: begin
            // A timeout abandons the whole batch, even if end_pool shows up the same cycle.
            if (timeout)           state_next = DONE;
            else if (bus.end_pool) state_next = last_img ? DONE : NEXT;
         end
         NEXT:    state_next = START;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   assign clr_cnt = accept || (state == START) || (state == NEXT);

   always_ff @(posedge clk1) begin
      if (rst) begin
         error    <= 1'b0;
         num_img  <= '0;
         img_idx  <= '0;
         ifm_base <= '0;
         ofm_base <= '0;
         ifm_cnt  <= '0;
         wgt_cnt  <= '0;
         out_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         if (accept) begin
            error    <= 1'b0;
            num_img  <= bus.cmd_num_img;
            img_idx  <= '0;
            ifm_base <= '0;
            ofm_base <= '0;
         end
         if (clr_cnt) begin
            ifm_cnt  <= '0;
            wgt_cnt  <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
         end
         if (state == NEXT) begin
            img_idx  <= img_idx + IMG_CNT_WIDTH'(1);
            ifm_base <= ifm_base + IFM_STEP;
            ofm_base <= ofm_base + OUT_FULL;
         end
         if (state == RUN) begin
            if (bus.ifm_read && (ifm_cnt != IFM_LAST)) ifm_cnt <= ifm_cnt + ADDR_WIDTH'(1);
            if (bus.wgt_read) wgt_cnt <= (wgt_cnt == WGT_LAST) ? '0 : wgt_cnt + ADDR_WIDTH'(1);
            if (out_ok) out_cnt <= out_cnt + ADDR_WIDTH'(1);
            idle_cnt <= active ? '0 : idle_cnt + TW'(1);
            // Error sources: surplus result beat, short image at end_pool, stalled engine.
            if (bus.out_valid && !out_ok)               error <= 1'b1;
            if (bus.end_pool && (end_cnt != OUT_FULL))  error <= 1'b1;
            if (timeout)                                error <= 1'b1;
         end
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.start_conv = (state == START);
   assign bus.error      = error;
   assign bus.img_idx    = img_idx;
   assign bus.ifm_addr   = ifm_base + ifm_cnt;
   assign bus.wgt_addr   = wgt_cnt;
   assign bus.ofm_addr   = ofm_base + out_cnt;
   assign bus.ofm_we     = (state == RUN) && out_ok;
   assign bus.fsm_state  = state;
endmodule

// File: tb/tb_conv_pool_sched.sv
// Directed bench for conv_pool_sched: single and multi-image batches, timeout,
// short/overfull images, weight wrap, busy-ignore, empty batch and mid-batch reset.
module tb_conv_pool_sched;
   localparam int TO        = 100;
   localparam int IFM_WORDS = 2187;
   localparam int WGT_WORDS = 600;
   localparam int OUT_WORDS = 1352;

   logic clk1;
   logic rst;
   int   checks   = 0;
   int   errors   = 0;
   int   sc_cnt   = 0;
   int   done_cnt = 0;
   int   sc_b, done_b, k;

   conv_pool_sched_if bus ();

   conv_pool_sched #(.TIMEOUT_CYCLES(TO)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   always @(negedge clk1) begin
      if (bus.start_conv) sc_cnt++;
      if (bus.done)       done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk1);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_strobes();
      bus.ifm_read  = 1'b0;
      bus.wgt_read  = 1'b0;
      bus.out_valid = 1'b0;
      bus.end_pool  = 1'b0;
   endtask

   task automatic send_cmd(input int n);
      bus.cmd_start   = 1'b1;
      bus.cmd_num_img = 8'(n);
      tick();
      bus.cmd_start   = 1'b0;
   endtask

   // Engine model: ifm reads from cycle 0, weight reads from cycle 0, result beats packed at the end.
   task automatic run_image(input int img, input int n_wgt, input int n_out, input bit merge_end);
      int l, first_out, beat, exp_i, exp_w;
      l = IFM_WORDS;
      if (n_wgt > l) l = n_wgt;
      if (n_out > l) l = n_out;
      first_out = l - n_out;
      for (int i = 0; i < l; i++) begin
         bus.ifm_read  = (i < IFM_WORDS);
         bus.wgt_read  = (i < n_wgt);
         bus.out_valid = (i >= first_out);
         bus.end_pool  = merge_end && (i == l - 1);
         #1;
         exp_i = (i < IFM_WORDS - 1) ? i : IFM_WORDS - 1;
         exp_w = ((i < n_wgt) ? i : n_wgt) % WGT_WORDS;
         chk("ifm_addr", bus.ifm_addr, img * IFM_WORDS + exp_i);
         chk("wgt_addr", bus.wgt_addr, exp_w);
         if (i >= first_out) begin
            beat = i - first_out;
            chk("ofm_we", bus.ofm_we, (beat < OUT_WORDS) ? 1 : 0);
            if (beat < OUT_WORDS) chk("ofm_addr", bus.ofm_addr, img * OUT_WORDS + beat);
         end else begin
            chk("ofm_we_idle", bus.ofm_we, 0);
         end
         tick();
      end
      clear_strobes();
      if (!merge_end) begin
         bus.end_pool = 1'b1;
         tick();
         bus.end_pool = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_start   = 1'b0;
      bus.cmd_num_img = '0;
      clear_strobes();
      repeat (3) tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_start_conv", bus.start_conv, 0);
      chk("rst_img_idx", bus.img_idx, 0);
      chk("rst_ifm_addr", bus.ifm_addr, 0);
      chk("rst_wgt_addr", bus.wgt_addr, 0);
      chk("rst_ofm_addr", bus.ofm_addr, 0);
      chk("rst_state", bus.fsm_state, 0);
      rst = 1'b0;
      tick();

      // Result beat while idle must not write
      bus.out_valid = 1'b1;
      #1;
      chk("idle_ofm_we", bus.ofm_we, 0);
      tick();
      bus.out_valid = 1'b0;
      chk("idle_no_count", bus.ofm_addr, 0);

      // Single image
      sc_b = sc_cnt;
      done_b = done_cnt;
      send_cmd(1);
      chk("one_start_conv", bus.start_conv, 1);
      chk("one_busy", bus.busy, 1);
      tick();
      chk("one_start_pulse", bus.start_conv, 0);
      run_image(0, WGT_WORDS, OUT_WORDS, 1'b0);
      chk("one_done", bus.done, 1);
      chk("one_error", bus.error, 0);
      chk("one_busy_done", bus.busy, 1);
      tick();
      chk("one_done_pulse", bus.done, 0);
      chk("one_busy_clr", bus.busy, 0);
      tick();
      chk("one_sc_count", sc_cnt - sc_b, 1);
      chk("one_done_count", done_cnt - done_b, 1);

      // Three images, with a cmd_start while busy in the gap
      sc_b = sc_cnt;
      send_cmd(3);
      chk("three_start0", bus.start_conv, 1);
      tick();
      for (int img = 0; img < 3; img++) begin
         if (img > 0) begin
            chk("gap_no_start", bus.start_conv, 0);
            bus.cmd_start   = 1'b1;
            bus.cmd_num_img = 8'd0;
            tick();
            bus.cmd_start   = 1'b0;
            chk("gap_start_conv", bus.start_conv, 1);
            chk("gap_ifm_base", bus.ifm_addr, img * IFM_WORDS);
            chk("gap_ofm_base", bus.ofm_addr, img * OUT_WORDS);
            chk("gap_img_idx", bus.img_idx, img);
            tick();
         end
         run_image(img, WGT_WORDS, OUT_WORDS, 1'b0);
      end
      chk("three_done", bus.done, 1);
      chk("three_error", bus.error, 0);
      chk("three_img_idx", bus.img_idx, 2);
      tick();
      tick();
      chk("three_sc_count", sc_cnt - sc_b, 3);

      // Engine stall -> timeout
      sc_b = sc_cnt;
      send_cmd(2);
      tick();
      bus.ifm_read = 1'b1;
      repeat (5) tick();
      bus.ifm_read = 1'b0;
      k = 0;
      while (!bus.done && k < 3 * TO) begin
         tick();
         k++;
      end
      chk("to_cycles", k, TO);
      chk("to_done", bus.done, 1);
      chk("to_error", bus.error, 1);
      repeat (5) tick();
      chk("to_busy", bus.busy, 0);
      chk("to_error_sticky", bus.error, 1);
      chk("to_sc_count", sc_cnt - sc_b, 1);

      // Empty batch clears error and finishes at once
      sc_b = sc_cnt;
      send_cmd(0);
      chk("zero_done", bus.done, 1);
      chk("zero_error", bus.error, 0);
      chk("zero_start_conv", bus.start_conv, 0);
      chk("zero_state", bus.fsm_state, 4);
      tick();
      chk("zero_busy", bus.busy, 0);
      tick();
      chk("zero_sc_count", sc_cnt - sc_b, 0);

      // Short image: end_pool after 1351 beats
      send_cmd(1);
      tick();
      run_image(0, WGT_WORDS, OUT_WORDS - 1, 1'b0);
      chk("short_done", bus.done, 1);
      chk("short_error", bus.error, 1);
      tick();

      // Last beat together with end_pool, 1201 weight reads
      send_cmd(1);
      chk("merge_err_clr", bus.error, 0);
      tick();
      run_image(0, 2 * WGT_WORDS + 1, OUT_WORDS, 1'b1);
      chk("merge_done", bus.done, 1);
      chk("merge_error", bus.error, 0);
      tick();

      // One surplus beat
      send_cmd(1);
      tick();
      run_image(0, WGT_WORDS, OUT_WORDS + 1, 1'b0);
      chk("over_error", bus.error, 1);
      tick();

      // Reset in the middle of a batch
      done_b = done_cnt;
      send_cmd(2);
      tick();
      bus.ifm_read  = 1'b1;
      bus.wgt_read  = 1'b1;
      bus.out_valid = 1'b1;
      repeat (50) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_strobes();
      chk("mid_rst_state", bus.fsm_state, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_error", bus.error, 0);
      chk("mid_rst_ifm", bus.ifm_addr, 0);
      chk("mid_rst_wgt", bus.wgt_addr, 0);
      chk("mid_rst_ofm", bus.ofm_addr, 0);
      chk("mid_rst_img", bus.img_idx, 0);
      repeat (3) tick();
      chk("mid_rst_no_done", done_cnt - done_b, 0);
      send_cmd(1);
      chk("post_rst_start", bus.start_conv, 1);
      tick();
      run_image(0, WGT_WORDS, OUT_WORDS, 1'b0);
      chk("post_rst_done", bus.done, 1);
      chk("post_rst_error", bus.error, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
